// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the execute-side pipeline blocks:
// datapath widths, the ALU operation encoding and a legality helper.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 16;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_AND = 3'b000;
  localparam alu_ctrl_t ALU_OR  = 3'b001;
  localparam alu_ctrl_t ALU_ADD = 3'b010;
  localparam alu_ctrl_t ALU_SUB = 3'b110;
  localparam alu_ctrl_t ALU_MUL = 3'b011;

  // The ALU only decodes these five codes.
  // Anything else is treated as an illegal instruction.
  function automatic logic alu_ctrl_legal(input alu_ctrl_t code);
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Signal bundle between decode / later pipeline stages and the ID/EX
// operand stage. The master modport is the pipeline around the stage.
// The slave modport is the stage itself.
interface ex_operand_stage_if #(
  parameter int XLEN    = cpu_pkg::XLEN,
  parameter int RADDR_W = cpu_pkg::RADDR_W,
  parameter int CNT_W   = cpu_pkg::CNT_W
) ();
  import cpu_pkg::*;

  // pipeline control
  logic               stall_i;
  logic               flush_i;

  // decode stage
  logic               id_valid_i;
  logic [XLEN-1:0]    id_rs1_data_i;
  logic [XLEN-1:0]    id_rs2_data_i;
  logic [XLEN-1:0]    id_imm_i;
  logic [RADDR_W-1:0] id_rs1_addr_i;
  logic [RADDR_W-1:0] id_rs2_addr_i;
  logic [RADDR_W-1:0] id_rd_addr_i;
  logic               id_alu_src_i;
  alu_ctrl_t          id_alu_ctrl_i;
  logic               id_reg_write_i;

  // forwarding sources
  logic               exmem_reg_write_i;
  logic [RADDR_W-1:0] exmem_rd_addr_i;
  logic [XLEN-1:0]    exmem_result_i;
  logic               memwb_reg_write_i;
  logic [RADDR_W-1:0] memwb_rd_addr_i;
  logic [XLEN-1:0]    memwb_data_i;

  // towards the ALU / EX stage
  logic [XLEN-1:0]    alu_data1_o;
  logic [XLEN-1:0]    alu_data2_o;
  alu_ctrl_t          alu_ctrl_o;
  logic               ex_valid_o;
  logic [RADDR_W-1:0] ex_rd_addr_o;
  logic               ex_reg_write_o;
  logic [XLEN-1:0]    ex_store_data_o;
  logic               illegal_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  modport master (
    output stall_i, flush_i,
    output id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
    output id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
    output id_alu_src_i, id_alu_ctrl_i, id_reg_write_i,
    output exmem_reg_write_i, exmem_rd_addr_i, exmem_result_i,
    output memwb_reg_write_i, memwb_rd_addr_i, memwb_data_i,
    input  alu_data1_o, alu_data2_o, alu_ctrl_o, ex_valid_o,
    input  ex_rd_addr_o, ex_reg_write_o, ex_store_data_o,
    input  illegal_o, stall_cnt_o
  );

  modport slave (
    input  stall_i, flush_i,
    input  id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
    input  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
    input  id_alu_src_i, id_alu_ctrl_i, id_reg_write_i,
    input  exmem_reg_write_i, exmem_rd_addr_i, exmem_result_i,
    input  memwb_reg_write_i, memwb_rd_addr_i, memwb_data_i,
    output alu_data1_o, alu_data2_o, alu_ctrl_o, ex_valid_o,
    output ex_rd_addr_o, ex_reg_write_o, ex_store_data_o,
    output illegal_o, stall_cnt_o
  );

endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding selector for one source register.
// EX/MEM wins over MEM/WB. Register x0 is hard-wired zero, so a write to
// it is never forwarded.
module fwd_mux #(
  parameter int XLEN    = cpu_pkg::XLEN,
  parameter int RADDR_W = cpu_pkg::RADDR_W
) (
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]    rs_data,
  input  logic               exmem_we,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_data,
  input  logic               memwb_we,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_data,
  output logic [XLEN-1:0]    fwd_data
);
  import cpu_pkg::*;

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_we && (exmem_rd != '0) && (exmem_rd == rs_addr);
  assign memwb_hit = memwb_we && (memwb_rd != '0) && (memwb_rd == rs_addr);

  // Choose the youngest in-flight producer of rs, else the register-file value.
  always_comb begin
    fwd_data = rs_data;
    if (exmem_hit) begin
      fwd_data = exmem_data;
    end else if (memwb_hit) begin
      fwd_data = memwb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU.
// It captures decoded operands and control, and supports stall and flush.
// It forwards results from EX/MEM and MEM/WB and counts stall cycles for
// performance debug.
// Build option: define EX_OPERAND_FWD_EN to enable the forwarding muxes.
// Without it, operands come straight from the registered register-file
// data, and hazards must be covered by stalls.
module ex_operand_stage #(
  parameter int XLEN    = cpu_pkg::XLEN,
  parameter int RADDR_W = cpu_pkg::RADDR_W,
  parameter int CNT_W   = cpu_pkg::CNT_W
) (
  input logic               clk_i,
  input logic               rst_i,
  ex_operand_stage_if.slave bus
);
  import cpu_pkg::*;

  logic               valid_q;
  logic [XLEN-1:0]    rs1_data_q;
  logic [XLEN-1:0]    rs2_data_q;
  logic [XLEN-1:0]    imm_q;
  logic [RADDR_W-1:0] rs1_addr_q;
  logic [RADDR_W-1:0] rs2_addr_q;
  logic [RADDR_W-1:0] rd_addr_q;
  logic               alu_src_q;
  alu_ctrl_t          alu_ctrl_q;
  logic               reg_write_q;
  logic               illegal_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    op_b_reg;
  logic               exmem_fwd_en;
  logic               memwb_fwd_en;

  // Stage register: reset > flush > stall > load.
  // The stall counter survives flushes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= ALU_AND;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else if (bus.flush_i) begin
      valid_q     <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= ALU_AND;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.stall_i) begin
      if (stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end else begin
      valid_q     <= bus.id_valid_i;
      rs1_data_q  <= bus.id_rs1_data_i;
      rs2_data_q  <= bus.id_rs2_data_i;
      imm_q       <= bus.id_imm_i;
      rs1_addr_q  <= bus.id_rs1_addr_i;
      rs2_addr_q  <= bus.id_rs2_addr_i;
      rd_addr_q   <= bus.id_rd_addr_i;
      alu_src_q   <= bus.id_alu_src_i;
      reg_write_q <= bus.id_reg_write_i;
      if (alu_ctrl_legal(bus.id_alu_ctrl_i)) begin
        alu_ctrl_q <= bus.id_alu_ctrl_i;
        illegal_q  <= 1'b0;
      end else begin
        // Illegal codes are neutralised to ADD and flagged for the trap logic.
        alu_ctrl_q <= ALU_ADD;
        illegal_q  <= 1'b1;
      end
    end
  end

`ifdef EX_OPERAND_FWD_EN
  assign exmem_fwd_en = bus.exmem_reg_write_i;
  assign memwb_fwd_en = bus.memwb_reg_write_i;
`else
  // Forwarding disabled: the muxes always fall through to register data.
  assign exmem_fwd_en = 1'b0;
  assign memwb_fwd_en = 1'b0;
  logic unused_fwd_we;
  assign unused_fwd_we = bus.exmem_reg_write_i ^ bus.memwb_reg_write_i;
`endif

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
    .rs_addr    (rs1_addr_q),
    .rs_data    (rs1_data_q),
    .exmem_we   (exmem_fwd_en),
    .exmem_rd   (bus.exmem_rd_addr_i),
    .exmem_data (bus.exmem_result_i),
    .memwb_we   (memwb_fwd_en),
    .memwb_rd   (bus.memwb_rd_addr_i),
    .memwb_data (bus.memwb_data_i),
    .fwd_data   (op_a)
  );

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
    .rs_addr    (rs2_addr_q),
    .rs_data    (rs2_data_q),
    .exmem_we   (exmem_fwd_en),
    .exmem_rd   (bus.exmem_rd_addr_i),
    .exmem_data (bus.exmem_result_i),
    .memwb_we   (memwb_fwd_en),
    .memwb_rd   (bus.memwb_rd_addr_i),
    .memwb_data (bus.memwb_data_i),
    .fwd_data   (op_b_reg)
  );

  // Operands stay combinational, so a stalled instruction still sees fresh forwards.
  assign bus.alu_data1_o     = op_a;
  assign bus.ex_store_data_o = op_b_reg;
  assign bus.alu_data2_o     = alu_src_q ? imm_q : op_b_reg;
  assign bus.alu_ctrl_o      = alu_ctrl_q;
  assign bus.ex_valid_o      = valid_q;
  assign bus.ex_rd_addr_o    = rd_addr_q;
  assign bus.ex_reg_write_o  = reg_write_q & valid_q;
  assign bus.illegal_o       = illegal_q;
  assign bus.stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage. It follows the forwarding
// build option through EX_OPERAND_FWD_EN.
module tb_ex_operand_stage;

`ifdef EX_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [3*XLEN+3+1+RADDR_W+1+1+CNT_W-1:0] pack_t;

  logic clk_i;
  logic rst_i;
  int   tests_run;
  int   tests_failed;

  ex_operand_stage_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) bus ();

  ex_operand_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: the instruction currently held by the stage.
  logic               m_valid;
  logic [XLEN-1:0]    m_rs1d, m_rs2d, m_imm;
  logic [RADDR_W-1:0] m_rs1a, m_rs2a, m_rd;
  logic               m_src, m_rw, m_ill;
  logic [2:0]         m_ctrl;
  int                 m_cnt;

  function automatic bit code_is_legal(input logic [2:0] c);
    return (c == 3'b000) || (c == 3'b001) || (c == 3'b010) ||
           (c == 3'b110) || (c == 3'b011);
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
    m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_src = 0; m_rw = 0; m_ill = 0; m_ctrl = 0;
  endtask

  // Apply one clock edge to the model, using the inputs present at that edge.
  task automatic model_edge();
    if (rst_i) begin
      model_clear();
      m_cnt = 0;
    end else if (bus.flush_i) begin
      model_clear();
    end else if (bus.stall_i) begin
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else begin
      m_valid = bus.id_valid_i;
      m_rs1d = bus.id_rs1_data_i; m_rs2d = bus.id_rs2_data_i; m_imm = bus.id_imm_i;
      m_rs1a = bus.id_rs1_addr_i; m_rs2a = bus.id_rs2_addr_i; m_rd = bus.id_rd_addr_i;
      m_src = bus.id_alu_src_i; m_rw = bus.id_reg_write_i;
      m_ill  = !code_is_legal(bus.id_alu_ctrl_i);
      m_ctrl = m_ill ? 3'b010 : bus.id_alu_ctrl_i;
    end
  endtask

  function automatic logic [XLEN-1:0] m_fwd(input logic [RADDR_W-1:0] a, input logic [XLEN-1:0] d);
    if (FWD && bus.exmem_reg_write_i && bus.exmem_rd_addr_i != 0 && bus.exmem_rd_addr_i == a)
      return bus.exmem_result_i;
    if (FWD && bus.memwb_reg_write_i && bus.memwb_rd_addr_i != 0 && bus.memwb_rd_addr_i == a)
      return bus.memwb_data_i;
    return d;
  endfunction

  function automatic pack_t exp_pack();
    logic [XLEN-1:0] a, st;
    a  = m_fwd(m_rs1a, m_rs1d);
    st = m_fwd(m_rs2a, m_rs2d);
    return {a, (m_src ? m_imm : st), m_ctrl, m_valid, m_rd, m_rw & m_valid, st, m_ill, m_cnt[CNT_W-1:0]};
  endfunction

  function automatic pack_t obs_pack();
    return {bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o, bus.ex_valid_o, bus.ex_rd_addr_o,
            bus.ex_reg_write_o, bus.ex_store_data_o, bus.illegal_o, bus.stall_cnt_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
    model_edge();
  endtask

  task automatic drive_id(input logic v, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                          input logic [XLEN-1:0] imm, input logic [RADDR_W-1:0] a1,
                          input logic [RADDR_W-1:0] a2, input logic [RADDR_W-1:0] rd,
                          input logic src, input logic [2:0] ctrl, input logic rw);
    bus.id_valid_i = v; bus.id_rs1_data_i = d1; bus.id_rs2_data_i = d2; bus.id_imm_i = imm;
    bus.id_rs1_addr_i = a1; bus.id_rs2_addr_i = a2; bus.id_rd_addr_i = rd;
    bus.id_alu_src_i = src; bus.id_alu_ctrl_i = ctrl; bus.id_reg_write_i = rw;
  endtask

  task automatic drive_fwd(input logic ew, input logic [RADDR_W-1:0] erd, input logic [XLEN-1:0] er,
                           input logic mw, input logic [RADDR_W-1:0] mrd, input logic [XLEN-1:0] md);
    bus.exmem_reg_write_i = ew; bus.exmem_rd_addr_i = erd; bus.exmem_result_i = er;
    bus.memwb_reg_write_i = mw; bus.memwb_rd_addr_i = mrd; bus.memwb_data_i = md;
  endtask

  task automatic test_reset();
    pack_t zero;
    zero = '0;
    drive_id(1'b1, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 5'd3, 5'd4, 5'd5, 1'b1, 3'b011, 1'b1);
    drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (obs_pack() !== zero) begin
        $display("FAIL reset_zero[%0d]: got %h expected %h", i, obs_pack(), zero);
        tests_failed++;
      end
    end
    rst_i = 1'b0;
    step();
    tests_run++;
    if ({bus.ex_valid_o, bus.alu_ctrl_o, bus.alu_data1_o} !== {1'b1, 3'b011, 32'h1111_2222}) begin
      $display("FAIL reset_release_load: got v=%b ctrl=%b a=%h expected v=1 ctrl=011 a=11112222",
               bus.ex_valid_o, bus.alu_ctrl_o, bus.alu_data1_o);
      tests_failed++;
    end
  endtask

  task automatic test_load();
    drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive_id(1'b1, 32'h5, 32'h3, 32'h77, 5'd1, 5'd2, 5'd3, 1'b0, 3'b110, 1'b1);
    step();
    tests_run++;
    if ({bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o, bus.ex_valid_o, bus.ex_reg_write_o}
        !== {32'd5, 32'd3, 3'b110, 1'b1, 1'b1}) begin
      $display("FAIL load_basic: got a=%h b=%h ctrl=%b v=%b rw=%b expected a=5 b=3 ctrl=110 v=1 rw=1",
               bus.alu_data1_o, bus.alu_data2_o, bus.alu_ctrl_o, bus.ex_valid_o, bus.ex_reg_write_o);
      tests_failed++;
    end
    tests_run++;
    if (obs_pack() !== exp_pack()) begin
      $display("FAIL load_model: got %h expected %h", obs_pack(), exp_pack());
      tests_failed++;
    end
  endtask

  task automatic test_fwd_priority();
    logic [XLEN-1:0] exp;
    drive_id(1'b1, 32'h11, 32'h22, 32'h0, 5'd7, 5'd4, 5'd9, 1'b0, 3'b010, 1'b1);
    step();
    drive_fwd(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB);
    #1;
    exp = FWD ? 32'hAA : 32'h11;
    tests_run++;
    if (bus.alu_data1_o !== exp) begin
      $display("FAIL fwd_exmem_priority: got %h expected %h", bus.alu_data1_o, exp);
      tests_failed++;
    end
    bus.exmem_reg_write_i = 1'b0;
    #1;
    exp = FWD ? 32'hBB : 32'h11;
    tests_run++;
    if (bus.alu_data1_o !== exp) begin
      $display("FAIL fwd_memwb: got %h expected %h", bus.alu_data1_o, exp);
      tests_failed++;
    end
    drive_id(1'b1, 32'h1234, 32'h22, 32'h0, 5'd0, 5'd4, 5'd9, 1'b0, 3'b010, 1'b1);
    step();
    drive_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    #1;
    tests_run++;
    if (bus.alu_data1_o !== 32'h1234) begin
      $display("FAIL fwd_x0_blocked: got %h expected 00001234", bus.alu_data1_o);
      tests_failed++;
    end
    tests_run++;
    if (obs_pack() !== exp_pack()) begin
      $display("FAIL fwd_model: got %h expected %h", obs_pack(), exp_pack());
      tests_failed++;
    end
  endtask

  task automatic test_imm_select();
    logic [XLEN-1:0] exp_st;
    drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive_id(1'b1, 32'h10, 32'h55, 32'hFFFF_FFFC, 5'd8, 5'd9, 5'd2, 1'b1, 3'b000, 1'b1);
    step();
    drive_fwd(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    #1;
    exp_st = FWD ? 32'hDEAD_BEEF : 32'h55;
    tests_run++;
    if ({bus.alu_data2_o, bus.ex_store_data_o} !== {32'hFFFF_FFFC, exp_st}) begin
      $display("FAIL imm_select: got b=%h st=%h expected b=fffffffc st=%h",
               bus.alu_data2_o, bus.ex_store_data_o, exp_st);
      tests_failed++;
    end
  endtask

  task automatic test_stall_flush();
    drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    drive_id(1'b1, 32'hCAFE, 32'hF00D, 32'h4, 5'd6, 5'd7, 5'd13, 1'b0, 3'b110, 1'b1);
    step();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'd20, 1'b0, 3'b001, 1'b0);
      step();
      tests_run++;
      if (obs_pack() !== exp_pack()) begin
        $display("FAIL stall_hold_model[%0d]: got %h expected %h", i, obs_pack(), exp_pack());
        tests_failed++;
      end
    end
    tests_run++;
    if ({bus.ex_rd_addr_o, bus.alu_ctrl_o, bus.ex_valid_o, bus.alu_data1_o, bus.stall_cnt_o}
        !== {5'd13, 3'b110, 1'b1, 32'hCAFE, 16'd3}) begin
      $display("FAIL stall_hold: got rd=%0d ctrl=%b v=%b a=%h cnt=%0d expected rd=13 ctrl=110 v=1 a=cafe cnt=3",
               bus.ex_rd_addr_o, bus.alu_ctrl_o, bus.ex_valid_o, bus.alu_data1_o, bus.stall_cnt_o);
      tests_failed++;
    end
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    tests_run++;
    if ({bus.ex_valid_o, bus.ex_reg_write_o, bus.ex_rd_addr_o, bus.stall_cnt_o}
        !== {1'b0, 1'b0, 5'd0, 16'd3}) begin
      $display("FAIL stall_flush_bubble: got v=%b rw=%b rd=%0d cnt=%0d expected v=0 rw=0 rd=0 cnt=3",
               bus.ex_valid_o, bus.ex_reg_write_o, bus.ex_rd_addr_o, bus.stall_cnt_o);
      tests_failed++;
    end
  endtask

  task automatic test_illegal();
    drive_id(1'b1, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 3'b101, 1'b1);
    step();
    tests_run++;
    if ({bus.alu_ctrl_o, bus.illegal_o} !== {3'b010, 1'b1}) begin
      $display("FAIL illegal_101: got ctrl=%b ill=%b expected ctrl=010 ill=1", bus.alu_ctrl_o, bus.illegal_o);
      tests_failed++;
    end
    bus.id_alu_ctrl_i = 3'b001;
    step();
    tests_run++;
    if ({bus.alu_ctrl_o, bus.illegal_o} !== {3'b001, 1'b0}) begin
      $display("FAIL illegal_clear: got ctrl=%b ill=%b expected ctrl=001 ill=0", bus.alu_ctrl_o, bus.illegal_o);
      tests_failed++;
    end
    for (int c = 0; c < 8; c++) begin
      bus.id_alu_ctrl_i = 3'(c);
      step();
      tests_run++;
      if (obs_pack() !== exp_pack()) begin
        $display("FAIL illegal_code[%0d]: got %h expected %h", c, obs_pack(), exp_pack());
        tests_failed++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst_i        = ($urandom_range(0, 39) == 0);
      bus.flush_i  = ($urandom_range(0, 9) == 0);
      bus.stall_i  = ($urandom_range(0, 4) == 0);
      drive_id(1'($urandom), $urandom, $urandom, $urandom, 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
      drive_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      #1;
      tests_run++;
      if (obs_pack() !== exp_pack()) begin
        $display("FAIL random_comb[%0d]: got %h expected %h", i, obs_pack(), exp_pack());
        tests_failed++;
      end
      step();
      tests_run++;
      if (obs_pack() !== exp_pack()) begin
        $display("FAIL random_edge[%0d]: got %h expected %h", i, obs_pack(), exp_pack());
        tests_failed++;
      end
    end
    rst_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
  endtask

  task automatic test_saturation();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    bus.stall_i = 1'b1;
    repeat (CNT_MAX - 1) step();
    tests_run++;
    if (bus.stall_cnt_o !== 16'hFFFE) begin
      $display("FAIL sat_below: got %h expected fffe", bus.stall_cnt_o);
      tests_failed++;
    end
    step();
    tests_run++;
    if (bus.stall_cnt_o !== 16'hFFFF) begin
      $display("FAIL sat_reach: got %h expected ffff", bus.stall_cnt_o);
      tests_failed++;
    end
    repeat (4) step();
    tests_run++;
    if (bus.stall_cnt_o !== 16'hFFFF) begin
      $display("FAIL sat_hold: got %h expected ffff", bus.stall_cnt_o);
      tests_failed++;
    end
    tests_run++;
    if (obs_pack() !== exp_pack()) begin
      $display("FAIL sat_model: got %h expected %h", obs_pack(), exp_pack());
      tests_failed++;
    end
    bus.stall_i = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_i        = 1'b1;
    bus.stall_i  = 1'b0;
    bus.flush_i  = 1'b0;
    drive_id(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0);
    drive_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    model_clear();
    m_cnt = 0;

    test_reset();
    test_load();
    test_fwd_priority();
    test_imm_select();
    test_stall_flush();
    test_illegal();
    test_random();
    test_saturation();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
